// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM command-port arbiter.
//   ADDR_W      : SDRAM byte-address width
//   sdram_cmd_t : one registered single-word command
//   REQ_*       : requester indices (VGA has fixed priority)
package sdram_arb_pkg;

  localparam int unsigned ADDR_W = 26;

  localparam int unsigned REQ_VGA   = 0;
  localparam int unsigned REQ_DATA  = 1;
  localparam int unsigned REQ_INSTR = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [31:0]       wdata;
    logic [3:0]        wmask;
  } sdram_cmd_t;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Requester-side bus of the SDRAM arbiter.
//   master : requester side (drives req_*, receives req_ready and rsp_*)
//   slave  : arbiter side
//   req_valid/req_ready : per-requester handshake, req_ready one-hot or zero
//   req_addr/write/wdata/wmask : per-requester single-word command
//   rsp_valid/rsp_data  : one-hot read return, data shared by all requesters
interface sdram_arbiter_if #(
  parameter int unsigned NUM_REQ = 3
) ();
  import sdram_arb_pkg::*;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ-1:0][31:0]       req_wdata;
  logic [NUM_REQ-1:0][3:0]        req_wmask;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [31:0]                    rsp_data;

  modport master (
    output req_valid, req_addr, req_write, req_wdata, req_wmask,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_wdata, req_wmask,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/sdram_arb_tag_fifo.sv
// Synchronous FIFO holding the requester index of each outstanding read.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push/i_data  : write a tag (ignored when full)
//   i_pop/o_data   : o_data is the head; i_pop discards it (ignored when empty)
//   o_full, o_empty, o_count : occupancy status
module sdram_arb_tag_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_push, w_pop;

  assign o_full  = (r_count == CntW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Arbiter sharing the SDRAM controller command port between requesters.
// Requester 0 (VGA) has priority; 1..NUM_REQ-1 are served round-robin. One
// command is registered at a time; read tags are queued so returned data is
// routed back to its owner in issue order.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   req_bus (slave)         : requester handshake, commands and read returns
//   o_sdram_valid/i_sdram_ready, o_sdram_addr/write/wdata/wmask : command out
//   i_sdram_rvalid/i_sdram_rdata : in-order read data from the controller
//   o_err_underflow         : sticky, read data arrived with nothing pending
// Optional: define SDRAM_ARB_STARVE_EN to let a requester that has waited
// STARVE_LIMIT cycles win one grant over requester 0.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 3,
  parameter int unsigned PENDING_DEPTH = 8,
  parameter int unsigned STARVE_LIMIT  = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  sdram_arbiter_if.slave    req_bus,
  output logic              o_sdram_valid,
  input  logic              i_sdram_ready,
  output logic [ADDR_W-1:0] o_sdram_addr,
  output logic              o_sdram_write,
  output logic [31:0]       o_sdram_wdata,
  output logic [3:0]        o_sdram_wmask,
  input  logic              i_sdram_rvalid,
  input  logic [31:0]       i_sdram_rdata,
  output logic              o_err_underflow
);
  localparam int unsigned TagW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(PENDING_DEPTH) + 1;

  sdram_cmd_t         r_cmd;
  logic               r_cmd_full;
  logic [TagW-1:0]    r_rr_ptr;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [31:0]        r_rsp_data;
  logic               r_err;

  logic               w_arb_en, w_grant, w_push, w_pop;
  logic               w_fifo_full, w_fifo_empty;
  logic [CntW-1:0]    w_fifo_count;
  logic [TagW-1:0]    w_win, w_head, w_rr_next, w_starve_idx;
  logic [NUM_REQ-1:0] w_elig, w_ready;
  logic               w_starve_hit;

  // k-th candidate of the round-robin scan over 1..NUM_REQ-1 starting at ptr.
  function automatic logic [TagW-1:0] rr_idx(logic [TagW-1:0] ptr, int unsigned k);
    int unsigned s;
    s = (32'(ptr) - 1 + k) % (NUM_REQ - 1) + 1;
    return TagW'(s);
  endfunction

  // Reset gates arbitration so req_ready is low while reset is held.
  assign w_arb_en = i_rst_n & (~r_cmd_full | i_sdram_ready);

  // Reads block on the occupancy seen this cycle; a same-cycle pop does not help.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = req_bus.req_valid[i] &
                  (req_bus.req_write[i] | (w_fifo_count != CntW'(PENDING_DEPTH)));
    end
  end

`ifdef SDRAM_ARB_STARVE_EN
  localparam int unsigned WaitW = $clog2(STARVE_LIMIT + 1);
  logic [NUM_REQ-1:1][WaitW-1:0] r_wait;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait <= '0;
    end else begin
      for (int i = 1; i < NUM_REQ; i++) begin
        if (w_ready[i]) begin
          r_wait[i] <= '0;
        end else if (req_bus.req_valid[i] && r_wait[i] != WaitW'(STARVE_LIMIT)) begin
          r_wait[i] <= r_wait[i] + WaitW'(1);
        end
      end
    end
  end

  // Descending scan so the lowest starving index is the one left selected.
  always_comb begin
    w_starve_hit = 1'b0;
    w_starve_idx = '0;
    for (int i = NUM_REQ - 1; i >= 1; i--) begin
      if (w_elig[i] && r_wait[i] == WaitW'(STARVE_LIMIT)) begin
        w_starve_hit = 1'b1;
        w_starve_idx = TagW'(i);
      end
    end
  end
`else
  assign w_starve_hit = 1'b0;
  assign w_starve_idx = '0;
`endif

  always_comb begin
    w_grant = 1'b0;
    w_win   = '0;
    if (w_arb_en) begin
      if (w_starve_hit) begin
        w_grant = 1'b1;
        w_win   = w_starve_idx;
      end else if (w_elig[REQ_VGA]) begin
        w_grant = 1'b1;
        w_win   = TagW'(REQ_VGA);
      end else begin
        for (int k = 0; k < NUM_REQ - 1; k++) begin
          if (!w_grant && w_elig[rr_idx(r_rr_ptr, k)]) begin
            w_grant = 1'b1;
            w_win   = rr_idx(r_rr_ptr, k);
          end
        end
      end
    end
    w_ready = w_grant ? (NUM_REQ'(1) << w_win) : '0;
  end

  always_comb begin
    w_rr_next = r_rr_ptr;
    if (w_grant && w_win != '0) begin
      w_rr_next = (32'(w_win) + 1 >= NUM_REQ) ? TagW'(1) : w_win + TagW'(1);
    end
  end

  assign w_push = w_grant & ~req_bus.req_write[w_win] & ~w_fifo_full;
  assign w_pop  = i_sdram_rvalid & ~w_fifo_empty;

  sdram_arb_tag_fifo #(
    .WIDTH (TagW),
    .DEPTH (PENDING_DEPTH)
  ) u_tag_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_data  (w_win),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmd       <= '0;
      r_cmd_full  <= 1'b0;
      r_rr_ptr    <= TagW'(1);
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rr_ptr <= w_rr_next;
      if (w_grant) begin
        r_cmd_full  <= 1'b1;
        r_cmd.addr  <= req_bus.req_addr[w_win];
        r_cmd.write <= req_bus.req_write[w_win];
        r_cmd.wdata <= req_bus.req_wdata[w_win];
        r_cmd.wmask <= req_bus.req_wmask[w_win];
      end else if (i_sdram_ready) begin
        r_cmd_full <= 1'b0;
      end
      r_rsp_valid <= w_pop ? (NUM_REQ'(1) << w_head) : '0;
      if (w_pop) r_rsp_data <= i_sdram_rdata;
      if (i_sdram_rvalid && w_fifo_empty) r_err <= 1'b1;
    end
  end

  assign req_bus.req_ready = w_ready;
  assign req_bus.rsp_valid = r_rsp_valid;
  assign req_bus.rsp_data  = r_rsp_data;
  assign o_sdram_valid     = r_cmd_full;
  assign o_sdram_addr      = r_cmd.addr;
  assign o_sdram_write     = r_cmd.write;
  assign o_sdram_wdata     = r_cmd.wdata;
  assign o_sdram_wmask     = r_cmd.wmask;
  assign o_err_underflow   = r_err;

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;
  localparam int NR    = 3;
  localparam int DEPTH = 8;
  localparam int LIMIT = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sdram_ready = 1'b0;
  logic        sdram_rvalid = 1'b0;
  logic [31:0] sdram_rdata = '0;
  logic        sdram_valid, sdram_write, err;
  logic [25:0] sdram_addr;
  logic [31:0] sdram_wdata;
  logic [3:0]  sdram_wmask;

  sdram_arbiter_if #(.NUM_REQ(NR)) bus ();

  sdram_arbiter #(
    .NUM_REQ       (NR),
    .PENDING_DEPTH (DEPTH),
    .STARVE_LIMIT  (LIMIT)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .req_bus         (bus),
    .o_sdram_valid   (sdram_valid),
    .i_sdram_ready   (sdram_ready),
    .o_sdram_addr    (sdram_addr),
    .o_sdram_write   (sdram_write),
    .o_sdram_wdata   (sdram_wdata),
    .o_sdram_wmask   (sdram_wmask),
    .i_sdram_rvalid  (sdram_rvalid),
    .i_sdram_rdata   (sdram_rdata),
    .o_err_underflow (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  bit          m_full;
  logic [25:0] m_addr;
  bit          m_write;
  logic [31:0] m_wdata;
  logic [3:0]  m_wmask;
  int          m_rr;
  int          m_tags[$];
  logic [2:0]  m_rsp_valid;
  logic [31:0] m_rsp_data;
  bit          m_err;
  int          m_wait[NR];

  logic [2:0]  s_ready;
  int          s_win;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_addr = '0; m_write = 0; m_wdata = '0; m_wmask = '0;
    m_rr = 1; m_tags.delete(); m_rsp_valid = '0; m_rsp_data = '0; m_err = 0;
    for (int i = 0; i < NR; i++) m_wait[i] = 0;
  endtask

  // Who should win right now, from the arbitration rules; -1 for nobody.
  function automatic int model_winner();
    bit elig[NR];
    if (!rst_n) return -1;
    if (m_full && !sdram_ready) return -1;
    for (int i = 0; i < NR; i++)
      elig[i] = bus.req_valid[i] && (bus.req_write[i] || m_tags.size() < DEPTH);
`ifdef SDRAM_ARB_STARVE_EN
    for (int i = 1; i < NR; i++) if (elig[i] && m_wait[i] >= LIMIT) return i;
`endif
    if (elig[0]) return 0;
    for (int k = 0; k < NR - 1; k++) begin
      int i = 1 + (m_rr - 1 + k) % (NR - 1);
      if (elig[i]) return i;
    end
    return -1;
  endfunction

  task automatic chk_outputs();
    chk("sdram_valid", 64'(sdram_valid), 64'(m_full));
    chk("sdram_cmd", {1'b0, sdram_addr, sdram_write, sdram_wdata, sdram_wmask},
        {1'b0, m_addr, m_write, m_wdata, m_wmask});
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_rsp_valid));
    chk("rsp_data", 64'(bus.rsp_data), 64'(m_rsp_data));
    chk("err_underflow", 64'(err), 64'(m_err));
  endtask

  // Called at posedge+2 with inputs already driven; returns at next posedge+2.
  task automatic cycle();
    int w;
    #1;
    w = model_winner();
    s_win = w;
    s_ready = bus.req_ready;
    chk("req_ready", 64'(bus.req_ready), (w < 0) ? 64'd0 : (64'd1 << w));
    @(posedge clk);
    if (sdram_rvalid) begin
      if (m_tags.size() > 0) begin
        m_rsp_valid = 3'(1 << m_tags.pop_front());
        m_rsp_data  = sdram_rdata;
      end else begin
        m_rsp_valid = '0;
        m_err = 1;
      end
    end else begin
      m_rsp_valid = '0;
    end
    if (w >= 0) begin
      if (!bus.req_write[w]) m_tags.push_back(w);
      m_full  = 1;
      m_addr  = bus.req_addr[w];
      m_write = bus.req_write[w];
      m_wdata = bus.req_wdata[w];
      m_wmask = bus.req_wmask[w];
      if (w >= 1) m_rr = (w + 1 >= NR) ? 1 : w + 1;
    end else if (sdram_ready) begin
      m_full = 0;
    end
`ifdef SDRAM_ARB_STARVE_EN
    for (int i = 1; i < NR; i++) begin
      if (w == i) m_wait[i] = 0;
      else if (bus.req_valid[i] && m_wait[i] < LIMIT) m_wait[i]++;
    end
`endif
    #2;
    chk_outputs();
  endtask

  task automatic idle();
    bus.req_valid = '0;
    bus.req_write = '0;
    sdram_rvalid = 1'b0;
  endtask

  task automatic set_req(input int i, input bit wr, input logic [25:0] a,
                         input logic [31:0] d, input logic [3:0] m);
    bus.req_valid[i] = 1'b1;
    bus.req_write[i] = wr;
    bus.req_addr[i]  = a;
    bus.req_wdata[i] = d;
    bus.req_wmask[i] = m;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("reset_ready", 64'(bus.req_ready), 64'd0);
    chk_outputs();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i] = (i == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      bus.req_write[i] = ($urandom_range(0, 2) == 0);
      bus.req_addr[i]  = 26'($urandom) & ~26'h3;
      bus.req_wdata[i] = $urandom;
      bus.req_wmask[i] = 4'($urandom);
    end
    sdram_ready  = ($urandom_range(0, 3) != 0);
    sdram_rvalid = (m_tags.size() > 0) && ($urandom_range(0, 2) == 0);
    sdram_rdata  = $urandom;
  endtask

  initial begin
    int n2, first2;
    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_wmask = '0;

    // Reset with all requesters asserting
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 26'(i * 4), 32'(i), 4'hf);
    sdram_ready = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #2;
    chk("reset_ready", 64'(bus.req_ready), 64'd0);
    chk_outputs();
    rst_n = 1'b1;
    cycle();
    chk("first_grant_vga", 64'(s_ready), 64'b001);
    idle();
    repeat (2) cycle();

    // Round-robin between 1 and 2, then in-order returns
    do_reset();
    idle();
    set_req(1, 1'b0, 26'h10, '0, 4'hf);
    set_req(2, 1'b0, 26'h20, '0, 4'hf);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("rr_grant", 64'(s_ready), (k % 2 == 0) ? 64'b010 : 64'b100);
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      sdram_rvalid = 1'b1;
      sdram_rdata  = 32'hA000_0001 + 32'(k);
      cycle();
      chk("rr_rsp_valid", 64'(bus.rsp_valid), (k % 2 == 0) ? 64'b010 : 64'b100);
      chk("rr_rsp_data", 64'(bus.rsp_data), 64'(32'hA000_0001 + 32'(k)));
    end
    idle();
    cycle();
    chk("rsp_one_cycle", 64'(bus.rsp_valid), 64'd0);

    // Backpressure holds the command stable
    do_reset();
    idle();
    set_req(0, 1'b1, 26'h0000100, 32'hDEAD_BEEF, 4'b0011);
    cycle();
    chk("bp_grant", 64'(s_ready), 64'b001);
    sdram_ready = 1'b0;
    set_req(0, 1'b1, 26'h0000200, 32'h1234_5678, 4'hf);
    set_req(1, 1'b0, 26'h0000300, '0, 4'hf);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_no_ready", 64'(s_ready), 64'd0);
      chk("bp_valid", 64'(sdram_valid), 64'd1);
      chk("bp_fields", {1'b0, sdram_addr, sdram_write, sdram_wdata, sdram_wmask},
          {1'b0, 26'h0000100, 1'b1, 32'hDEAD_BEEF, 4'b0011});
    end
    sdram_ready = 1'b1;
    cycle();
    chk("bp_release", 64'(s_ready), 64'b001);
    chk("bp_next_addr", 64'(sdram_addr), 64'h200);

    // Tag FIFO full blocks reads but not writes
    do_reset();
    idle();
    set_req(1, 1'b0, 26'h40, '0, 4'hf);
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("fill_grant", 64'(s_ready), 64'b010);
    end
    set_req(2, 1'b1, 26'h80, 32'h5555_AAAA, 4'hf);
    cycle();
    chk("full_write_granted", 64'(s_ready), 64'b100);
    bus.req_valid[2] = 1'b0;
    sdram_rvalid = 1'b1;
    sdram_rdata  = 32'hCAFE_0001;
    cycle();
    chk("full_read_held", 64'(s_ready), 64'd0);
    sdram_rvalid = 1'b0;
    cycle();
    chk("slot_freed", 64'(s_ready), 64'b010);
    idle();

    // Underflow is sticky and produces no response
    do_reset();
    idle();
    cycle();
    sdram_rvalid = 1'b1;
    sdram_rdata  = 32'h1111_2222;
    cycle();
    chk("underflow_set", 64'(err), 64'd1);
    chk("underflow_no_rsp", 64'(bus.rsp_valid), 64'd0);
    sdram_rvalid = 1'b0;
    repeat (3) cycle();
    chk("underflow_sticky", 64'(err), 64'd1);

    // Random traffic with a reset in the middle
    do_reset();
    repeat (200) begin
      randomize_inputs();
      cycle();
    end
    do_reset();
    chk("midreset_err", 64'(err), 64'd0);
    repeat (200) begin
      randomize_inputs();
      cycle();
    end

    // Requester 2 competing with a continuous requester 0
    do_reset();
    idle();
    sdram_ready = 1'b1;
    set_req(0, 1'b1, 26'h100, 32'h0, 4'hf);
    set_req(2, 1'b1, 26'h200, 32'h2, 4'hf);
    n2 = 0;
    first2 = -1;
    for (int c = 0; c < 100; c++) begin
      cycle();
      if (s_ready[2]) begin
        n2++;
        if (first2 < 0) first2 = c;
      end
    end
`ifdef SDRAM_ARB_STARVE_EN
    chk("starve_grants", 64'(n2), 64'd1);
    chk("starve_cycle", 64'(first2), 64'(LIMIT));
`else
    chk("starve_grants", 64'(n2), 64'd0);
`endif
    idle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
